fir_tpipe_param: RTL and testbench
==================================

Name: fir_tpipe_param

Overview:
- Parametrised transposed-form pipelined FIR; successor to the fixed 129-tap 33-bit filter.
- Adds sample-valid qualification, runtime double-buffered coefficients, and rounding/shift output scaling.
- Sits in the FIR_filter datapath between a sample source and downstream DSP.
- Each accepted input sample produces one output sample.

Parameters:
NTAPS, 16, number of taps, >=2
DW, 16, signed input sample width
CW, 16, signed coefficient width
OW, 16, signed output width
SHIFT, 15, arithmetic right shift applied to accumulator before output (coefficient fraction bits)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  x is a new sample this cycle
x  in  DW  signed input sample
coef_wr_en  in  1  write coef_wr_data into shadow bank
coef_wr_addr  in  $clog2(NTAPS)  shadow tap index
coef_wr_data  in  CW  signed coefficient
coef_swap  in  1  commit shadow bank to active bank
out_valid  out  1  y holds a new output sample
y  out  OW  signed filtered output

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, named reset.
- Reset values: out_valid=0, y=0, all product and partial-sum registers 0. Active and shadow coefficient banks are 0, so output is 0 until coefficients are loaded and swapped.
- Function: y[n] = sat_or_wrap(round(sum_{k=0..NTAPS-1} c[k]*x[n-k]) >>> SHIFT). Sample history counts accepted samples only; idle cycles are not zero samples.
- Stage 1, on in_valid:
  - p[k] <= c_active[k]*x for all k.
  - v1 <= in_valid every cycle.
- Stage 2, when v1:
  - s[k] <= s[k+1] + p[k] for k < NTAPS-1.
  - s[NTAPS-1] <= p[NTAPS-1].
  - v2 <= v1 every cycle.
- Partial sums hold when v1=0 (bubbles do not disturb state).
- Output: y is registered from s[0] together with v2. Latency is fixed: sample accepted at cycle t gives out_valid=1 at cycle t+3, for exactly one cycle per sample. Back-to-back in_valid gives back-to-back out_valid.
- Widths:
  - ACCW = DW+CW+$clog2(NTAPS).
  - All products and sums are sign-extended to ACCW, with no internal overflow.
  - Rounding: add 2^(SHIFT-1) then >>> SHIFT (round half up); SHIFT=0 means no rounding.
  - Without FIR_SAT_EN, the result is truncated to the low OW bits (two's-complement wrap).
- Coefficient write:
  - coef_wr_en writes the shadow bank at coef_wr_addr.
  - coef_wr_addr >= NTAPS is ignored.
  - The active bank is never written directly.
- Coefficient swap:
  - coef_swap copies the whole shadow bank to the active bank at the clock edge.
  - New coefficients apply to samples accepted from the next cycle on.
  - Samples already in flight finish with the products they captured, so outputs mix old and new coefficients for up to NTAPS-1 outputs (transposed-form property, accepted).
- Swap with write in the same cycle: the copy uses the pre-write shadow contents; the write still lands in shadow and needs another swap.
- Swap with in_valid in the same cycle: that sample uses the old active bank.
- Reset mid-stream: clears the pipeline and both banks. In-flight samples are discarded, and no out_valid follows a reset.

Optional Feature:
FIR_SAT_EN
- Defined:
  - After the shift, values above 2^(OW-1)-1 clamp to 2^(OW-1)-1.
  - Values below -2^(OW-1) clamp to -2^(OW-1).
  - Adds output sat_flag (1 bit, reset 0), valid with out_valid.
- Undefined: wrap truncation as above; no sat_flag port.

Decomposition:
- Package fir_pkg:
  - acc_width function.
  - Default DW/CW/OW constants.
  - Typedef for the coefficient bank array.
  - round_shift helper function.
- Sub-module fir_coef_bank: shadow/active banks, write decode, swap; exports the active bank array.

Test Plan (NTAPS=4, DW=CW=OW=16, SHIFT=0 unless stated):
- Load c={1,2,3,4}, swap, impulse x=1 then three x=0 -> y=1,2,3,4 at cycles t+3..t+6 with out_valid each; then 0.
- Same coefficients, x=1 valid every other cycle -> outputs 1,3,6,10,10; out_valid exactly 3 cycles after each in_valid; bubbles do not change the result.
- Write c[0]=5 and pulse coef_swap in the same cycle -> active c[0] stays 1. A second swap makes c[0]=5, and the impulse response becomes 5,2,3,4.
- SHIFT=1, c={3,0,0,0}, x=1 -> y=2 (round half up); x=-1 -> y=-1.
- c={32767,32767,0,0}, x=32767 twice -> wrap without FIR_SAT_EN; with it y=32767 and sat_flag=1.
- Assert reset two cycles after an impulse -> out_valid stays 0; a post-reset impulse gives y=0 (banks cleared).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, widths and helpers for the parametrised transposed FIR.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

    localparam int DEF_NTAPS = 16;
    localparam int DEF_DW    = 16;
    localparam int DEF_CW    = 16;
    localparam int DEF_OW    = 16;

    // Wide enough for any realistic accumulator plus rounding headroom.
    localparam int RSW = 128;

    // Coefficient bank shape at the default configuration.
    typedef logic signed [DEF_CW-1:0] coef_bank_t [DEF_NTAPS];

    // Accumulator width that cannot overflow for NTAPS full-scale products.
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    // Round half up, then arithmetic shift right; sh == 0 passes through.
    function automatic logic signed [RSW-1:0] round_shift(input logic signed [RSW-1:0] v,
                                                          input int sh);
        logic signed [RSW-1:0] half;
        if (sh == 0) begin
            return v;
        end
        half = 128'sd1 <<< (sh - 1);
        return (v + half) >>> sh;
    endfunction

endpackage

// File: rtl/fir_tpipe_param_if.sv
// Sample, coefficient-load and output bundle for fir_tpipe_param.
// Latency: n/a (wiring only).
// Backpressure: none; FIR_SAT_EN adds the sat_flag output.
interface fir_tpipe_param_if #(
    parameter int NTAPS = 16,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 16
);
    localparam int AW = $clog2(NTAPS);

    logic                 in_valid;
    logic signed [DW-1:0] x;
    logic                 coef_wr_en;
    logic [AW-1:0]        coef_wr_addr;
    logic signed [CW-1:0] coef_wr_data;
    logic                 coef_swap;
    logic                 out_valid;
    logic signed [OW-1:0] y;
`ifdef FIR_SAT_EN
    logic                 sat_flag;
`endif

    modport master (
        output in_valid, x, coef_wr_en, coef_wr_addr, coef_wr_data, coef_swap,
        input  out_valid, y
`ifdef FIR_SAT_EN
        , sat_flag
`endif
    );

    modport slave (
        input  in_valid, x, coef_wr_en, coef_wr_addr, coef_wr_data, coef_swap,
        output out_valid, y
`ifdef FIR_SAT_EN
        , sat_flag
`endif
    );

endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficients: writes go to shadow, swap copies shadow to active.
// Latency: a swap is visible on active the cycle after the swap edge.
// Backpressure: none; out-of-range write addresses simply match no tap.
module fir_coef_bank #(
    parameter int NTAPS = 16,
    parameter int CW    = 16,
    parameter int AW    = $clog2(NTAPS)
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [CW-1:0] wr_data,
    input  logic                 swap,
    output logic signed [CW-1:0] active [NTAPS]
);
    logic signed [CW-1:0] shadow [NTAPS];

    // Swap copies the pre-write shadow, since both read shadow's current value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                if (swap) begin
                    active[k] <= shadow[k];
                end
                if (wr_en && (wr_addr == AW'(k))) begin
                    shadow[k] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/fir_tpipe_param.sv
// Transposed-form pipelined FIR with double-buffered coefficients and round/shift scaling.
// Latency: 3 cycles from accepted in_valid to out_valid; one output per accepted sample.
// Backpressure: none, a sample may be accepted every cycle; FIR_SAT_EN selects clamping over wrap.
module fir_tpipe_param
    import fir_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW,
    parameter int OW    = DEF_OW,
    parameter int SHIFT = 15
)(
    input  logic             clk,
    input  logic             reset,
    fir_tpipe_param_if.slave bus
);
    localparam int ACCW = acc_width(DW, CW, NTAPS);
    localparam int AW   = $clog2(NTAPS);

    logic signed [CW-1:0]   c_active [NTAPS];
    logic signed [ACCW-1:0] p [NTAPS];
    logic signed [ACCW-1:0] s [NTAPS];
    logic                   v1;
    logic                   v2;
    logic signed [RSW-1:0]  rs;
    logic signed [OW-1:0]   y_n;

    fir_coef_bank #(
        .NTAPS (NTAPS),
        .CW    (CW),
        .AW    (AW)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.coef_wr_en),
        .wr_addr (bus.coef_wr_addr),
        .wr_data (bus.coef_wr_data),
        .swap    (bus.coef_swap),
        .active  (c_active)
    );

    // Stage 1: every tap multiplies the new sample by its active coefficient.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                p[k] <= '0;
            end
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                for (int k = 0; k < NTAPS; k++) begin
                    p[k] <= $signed({{(ACCW-CW){c_active[k][CW-1]}}, c_active[k]})
                          * $signed({{(ACCW-DW){bus.x[DW-1]}}, bus.x});
                end
            end
        end
    end

    // Stage 2: transposed adder chain; only advances on a real sample so bubbles are invisible.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2 <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                s[k] <= '0;
            end
        end else begin
            v2 <= v1;
            if (v1) begin
                for (int k = 0; k < NTAPS - 1; k++) begin
                    s[k] <= s[k+1] + p[k];
                end
                s[NTAPS-1] <= p[NTAPS-1];
            end
        end
    end

    assign rs = round_shift({{(RSW-ACCW){s[0][ACCW-1]}}, s[0]}, SHIFT);

`ifdef FIR_SAT_EN
    localparam logic signed [RSW-1:0] OMAX = (128'sd1 <<< (OW - 1)) - 128'sd1;
    localparam logic signed [RSW-1:0] OMIN = -(128'sd1 <<< (OW - 1));
    logic sat_n;

    // Clamp the scaled sum to the output range and flag when clamping happened.
    always_comb begin
        y_n   = rs[OW-1:0];
        sat_n = 1'b0;
        if (rs > OMAX) begin
            y_n   = OMAX[OW-1:0];
            sat_n = 1'b1;
        end else if (rs < OMIN) begin
            y_n   = OMIN[OW-1:0];
            sat_n = 1'b1;
        end
    end

    // Output register: sample, flag and valid leave together.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.sat_flag  <= 1'b0;
        end else begin
            bus.out_valid <= v2;
            if (v2) begin
                bus.y        <= y_n;
                bus.sat_flag <= sat_n;
            end
        end
    end
`else
    logic unused_rs_hi;
    assign unused_rs_hi = ^rs[RSW-1:OW];

    // Two's-complement wrap: keep only the low OW bits of the scaled sum.
    always_comb begin
        y_n = rs[OW-1:0];
    end

    // Output register: sample and valid leave together.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
        end else begin
            bus.out_valid <= v2;
            if (v2) begin
                bus.y <= y_n;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_tpipe_param.sv
// Bench for fir_tpipe_param: two instances (SHIFT=0 and SHIFT=1) driven identically.
// Latency: expects out_valid exactly 3 cycles after each accepted sample.
// Backpressure: none; checks against a sample-history reference model.
module tb_fir_tpipe_param;

    localparam int NT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fir_tpipe_param_if #(.NTAPS(NT), .DW(16), .CW(16), .OW(16)) bus0 ();
    fir_tpipe_param_if #(.NTAPS(NT), .DW(16), .CW(16), .OW(16)) bus1 ();

    fir_tpipe_param #(.NTAPS(NT), .DW(16), .CW(16), .OW(16), .SHIFT(0)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    fir_tpipe_param #(.NTAPS(NT), .DW(16), .CW(16), .OW(16), .SHIFT(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: each accepted sample remembers the products it formed with the
    // bank active when it was accepted; output n sums tap k of sample n-k.
    typedef longint prod_t [NT];
    typedef struct { longint acc; int due; } exp_t;

    longint act_m [NT];
    longint shd_m [NT];
    prod_t  hist [$];
    exp_t   exp_q [$];
    longint obs0 [$];
    longint obs1 [$];

    function automatic longint scale(input longint acc, input int sh);
        longint r;
        logic [63:0] rb;
        logic signed [15:0] lo;
        r = (sh == 0) ? acc : ((acc + (longint'(1) <<< (sh - 1))) >>> sh);
`ifdef FIR_SAT_EN
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return r;
`else
        rb = r;
        lo = rb[15:0];
        return longint'(lo);
`endif
    endfunction

    function automatic longint sat_of(input longint acc, input int sh);
        longint r;
        r = (sh == 0) ? acc : ((acc + (longint'(1) <<< (sh - 1))) >>> sh);
        return (r > 32767 || r < -32768) ? 1 : 0;
    endfunction

    task automatic step(input bit v, input int xv, input bit we, input int wa, input int wd,
                        input bit sw, input bit rs);
        prod_t  pr;
        longint acc;
        exp_t   e;
        @(posedge clk);
        #1;
        reset              = rs;
        bus0.in_valid      = v;  bus1.in_valid      = v;
        bus0.x             = 16'(xv); bus1.x        = 16'(xv);
        bus0.coef_wr_en    = we; bus1.coef_wr_en    = we;
        bus0.coef_wr_addr  = 2'(wa); bus1.coef_wr_addr = 2'(wa);
        bus0.coef_wr_data  = 16'(wd); bus1.coef_wr_data = 16'(wd);
        bus0.coef_swap     = sw; bus1.coef_swap     = sw;
        if (rs) begin
            hist.delete();
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].due > cyc) exp_q.delete(i);
            end
            for (int k = 0; k < NT; k++) begin
                act_m[k] = 0;
                shd_m[k] = 0;
            end
        end else begin
            if (v) begin
                for (int k = 0; k < NT; k++) pr[k] = act_m[k] * longint'(xv);
                hist.push_front(pr);
                if (hist.size() > NT) void'(hist.pop_back());
                acc = 0;
                for (int k = 0; k < hist.size(); k++) acc += hist[k][k];
                e.acc = acc;
                e.due = cyc + 3;
                exp_q.push_back(e);
            end
            if (sw) act_m = shd_m;
            if (we && wa < NT) shd_m[wa] = longint'(wd);
        end
    endtask

    task automatic idle();                    step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic smp(input int xv);         step(1, xv, 0, 0, 0, 0, 0); endtask
    task automatic wr(input int a, input int d); step(0, 0, 1, a, d, 0, 0); endtask
    task automatic swp();                     step(0, 0, 0, 0, 0, 1, 0); endtask
    task automatic drain();
        for (int i = 0; i < 6; i++) idle();
    endtask

    task automatic chk_obs(input string tag, input int which, input int idx, input longint v);
        if (which == 0) begin
            if (idx < obs0.size()) chk(tag, obs0[idx], v);
            else chk({tag, "_count"}, obs0.size(), idx + 1);
        end else begin
            if (idx < obs1.size()) chk(tag, obs1[idx], v);
            else chk({tag, "_count"}, obs1.size(), idx + 1);
        end
    endtask

    // Every cycle: out_valid must match the model's due schedule; values checked on valid.
    always @(negedge clk) begin
        bit   want;
        exp_t e;
        if (mon_en) begin
            want = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("out_valid0", bus0.out_valid, want);
            chk("out_valid1", bus1.out_valid, want);
            if (want) begin
                e = exp_q.pop_front();
                chk("y_shift0", bus0.y, scale(e.acc, 0));
                chk("y_shift1", bus1.y, scale(e.acc, 1));
`ifdef FIR_SAT_EN
                chk("sat_flag0", bus0.sat_flag, sat_of(e.acc, 0));
                chk("sat_flag1", bus1.sat_flag, sat_of(e.acc, 1));
`endif
                obs0.push_back(bus0.y);
                obs1.push_back(bus1.y);
            end
        end
    end

    initial begin
        logic signed [15:0] r16;
        logic signed [15:0] c16;

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_y", bus0.y, 0);
        mon_en = 1'b1;
        idle();

        // Impulse response with c = {1,2,3,4}
        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4); swp();
        obs0.delete();
        smp(1); smp(0); smp(0); smp(0); smp(0);
        drain();
        chk_obs("impulse0", 0, 0, 1);
        chk_obs("impulse1", 0, 1, 2);
        chk_obs("impulse2", 0, 2, 3);
        chk_obs("impulse3", 0, 3, 4);
        chk_obs("impulse4", 0, 4, 0);

        // Ones every other cycle: bubbles must not disturb the running sum
        obs0.delete();
        for (int i = 0; i < 5; i++) begin
            smp(1);
            idle();
        end
        drain();
        chk_obs("bubble0", 0, 0, 1);
        chk_obs("bubble1", 0, 1, 3);
        chk_obs("bubble2", 0, 2, 6);
        chk_obs("bubble3", 0, 3, 10);
        chk_obs("bubble4", 0, 4, 10);

        // Write and swap in the same cycle: swap takes the old shadow value
        step(0, 0, 1, 0, 5, 1, 0);
        smp(0); smp(0); smp(0);
        drain();
        obs0.delete();
        smp(1); smp(0); smp(0); smp(0);
        drain();
        chk_obs("sameswap_c0", 0, 0, 1);
        chk_obs("sameswap_c1", 0, 1, 2);
        swp();
        smp(0); smp(0); smp(0);
        drain();
        obs0.delete();
        smp(1); smp(0); smp(0); smp(0);
        drain();
        chk_obs("swap2_c0", 0, 0, 5);
        chk_obs("swap2_c1", 0, 1, 2);
        chk_obs("swap2_c2", 0, 2, 3);
        chk_obs("swap2_c3", 0, 3, 4);

        // Round half up on the SHIFT=1 instance
        wr(0, 3); wr(1, 0); wr(2, 0); wr(3, 0); swp();
        smp(0); smp(0); smp(0);
        drain();
        obs1.delete();
        smp(1);
        smp(-1);
        drain();
        chk_obs("round_pos", 1, 0, 2);
        chk_obs("round_neg", 1, 1, -1);

        // Overflow of the output range: wrap, or clamp with the saturation build
        wr(0, 32767); wr(1, 32767); swp();
        smp(0); smp(0); smp(0);
        drain();
        obs0.delete();
        smp(32767);
        smp(32767);
        drain();
`ifdef FIR_SAT_EN
        chk_obs("ovf0", 0, 0, 32767);
        chk_obs("ovf1", 0, 1, 32767);
`else
        chk_obs("ovf0", 0, 0, 1);
        chk_obs("ovf1", 0, 1, 2);
`endif

        // Reset with a sample in flight: no out_valid, banks cleared
        smp(1);
        idle();
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("post_rst_quiet", bus0.out_valid, 0);
        end
        obs0.delete();
        smp(1);
        drain();
        chk_obs("post_rst_impulse", 0, 0, 0);

        // Randomized traffic with occasional writes, swaps and resets
        for (int i = 0; i < 400; i++) begin
            r16 = 16'($urandom);
            c16 = 16'($urandom);
            step($urandom_range(0, 3) != 0, int'(r16), $urandom_range(0, 3) == 0,
                 $urandom_range(0, NT - 1), int'(c16), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 149) == 0);
        end
        drain();
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
